// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: operation encoding and
// the fixed-priority control decode.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // call > ret > loadPC > incPC > hold
  function automatic pc_op_e pc_decode(input logic call, input logic ret,
                                       input logic load_pc, input logic inc_pc);
    if (call)         return PC_CALL;
    else if (ret)     return PC_RET;
    else if (load_pc) return PC_LOAD;
    else if (inc_pc)  return PC_INC;
    else              return PC_HOLD;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO. Reset clears only the pointer; storage keeps stale data.
// Push when full and pop when empty are ignored.
module lifo_stack #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push && !full) begin
      count_d = count_q + CW'(1);
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == count_q) mem_d[i] = push_data;
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  // Reads as zero when empty so the output never exposes stale storage.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!empty && CW'(i) == count_q - CW'(1)) top = mem_q[i];
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with a hardware return-address stack and
// sticky overflow/underflow reporting.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int          ADDR_W     = 12,
  parameter int          DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addressIn,
  input  logic                       incPC,
  input  logic                       loadPC,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       clearErr,
  output logic [ADDR_W-1:0]          addressOut,
  output logic [ADDR_W-1:0]          topOfStack,
  output logic [$clog2(DEPTH+1)-1:0] stackCount,
  output logic                       stackFull,
  output logic                       stackEmpty,
  output logic                       overflow,
  output logic                       underflow
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop;

  assign op         = pc_decode(call, ret, loadPC, incPC);
  assign pc_inc     = pc_q + ADDR_W'(1);
  assign addressOut = pc_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    // A new error in the same cycle as clearErr leaves the flag set.
    ovf_d = ovf_q & ~clearErr;
    unf_d = unf_q & ~clearErr;
    unique case (op)
      PC_INC:  pc_d = pc_inc;
      PC_LOAD: pc_d = addressIn;
      PC_CALL:
        if (stackFull) ovf_d = 1'b1;
        else begin
          push = 1'b1;
          pc_d = addressIn;
        end
      PC_RET:
        if (stackEmpty) unf_d = 1'b1;
        else begin
          pop  = 1'b1;
          pc_d = topOfStack;
        end
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  lifo_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (topOfStack),
    .count     (stackCount),
    .full      (stackFull),
    .empty     (stackEmpty)
  );

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (ADDR_W=12, DEPTH=4, RESET_ADDR=0x100).
module tb_program_counter_stack;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] RST = 12'h100;

  logic              clk = 1'b0;
  logic              reset, incPC, loadPC, call, ret, clearErr;
  logic [ADDR_W-1:0] addressIn, addressOut, topOfStack;
  logic [2:0]        stackCount;
  logic              stackFull, stackEmpty, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_counter_stack #(
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addressIn  (addressIn),
    .incPC      (incPC),
    .loadPC     (loadPC),
    .call       (call),
    .ret        (ret),
    .clearErr   (clearErr),
    .addressOut (addressOut),
    .topOfStack (topOfStack),
    .stackCount (stackCount),
    .stackFull  (stackFull),
    .stackEmpty (stackEmpty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply controls for one edge, then sample 1 time unit after it.
  task automatic cyc(input logic r, input logic c, input logic rt, input logic ld,
                     input logic inc, input logic clr, input logic [ADDR_W-1:0] a);
    reset = r; call = c; ret = rt; loadPC = ld; incPC = inc; clearErr = clr; addressIn = a;
    @(posedge clk);
    #1;
    reset = 0; call = 0; ret = 0; loadPC = 0; incPC = 0; clearErr = 0;
  endtask

  initial begin
    reset = 1; call = 0; ret = 0; loadPC = 0; incPC = 0; clearErr = 0; addressIn = '0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_addr",  addressOut, 32'h100);
    chk("rst_cnt",   stackCount, 0);
    chk("rst_empty", stackEmpty, 1);
    chk("rst_full",  stackFull, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_unf",   underflow, 0);
    chk("rst_tos",   topOfStack, 0);

    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      chk("inc_addr", addressOut, 32'h100 + i);
    end
    chk("inc_empty", stackEmpty, 1);

    // Wrap-around
    cyc(0, 0, 0, 1, 0, 0, 12'hFFF);
    chk("load_fff", addressOut, 32'hFFF);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("wrap_addr", addressOut, 32'h000);
    chk("wrap_ovf",  overflow, 0);
    chk("wrap_unf",  underflow, 0);

    // Single call/ret
    cyc(0, 0, 0, 1, 0, 0, 12'h010);
    cyc(0, 1, 0, 0, 0, 0, 12'h200);
    chk("call_addr", addressOut, 32'h200);
    chk("call_tos",  topOfStack, 32'h011);
    chk("call_cnt",  stackCount, 1);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("ret_addr",  addressOut, 32'h011);
    chk("ret_empty", stackEmpty, 1);

    // Nested calls to overflow
    cyc(0, 0, 0, 1, 0, 0, 12'h020);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, 12'h300 + 12'(i));
    chk("ovf_addr", addressOut, 32'h303);
    chk("ovf_full", stackFull, 1);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt",  stackCount, 4);
    chk("ovf_tos",  topOfStack, 32'h303);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("unwind1", addressOut, 32'h303);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("unwind2", addressOut, 32'h302);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("unwind3", addressOut, 32'h301);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("unwind4", addressOut, 32'h021);
    chk("unwind_empty", stackEmpty, 1);
    chk("ovf_sticky", overflow, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_clear", overflow, 0);

    // Underflow and clearErr interaction
    cyc(0, 0, 0, 1, 0, 0, 12'h050);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("unf_addr", addressOut, 32'h050);
    chk("unf_flag", underflow, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("unf_clear", underflow, 0);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("unf_set_wins", underflow, 1);
    chk("unf_hold_addr", addressOut, 32'h050);
    cyc(0, 0, 0, 0, 0, 1, 0);

    // Priority: call beats everything
    cyc(0, 0, 0, 1, 0, 0, 12'h040);
    cyc(0, 1, 1, 1, 1, 0, 12'h123);
    chk("prio_addr", addressOut, 32'h123);
    chk("prio_tos",  topOfStack, 32'h041);
    chk("prio_cnt",  stackCount, 1);
    // ret beats load when stack non-empty
    cyc(0, 0, 1, 1, 1, 0, 12'h777);
    chk("prio_ret", addressOut, 32'h041);

    // Reset wins over a simultaneous call
    cyc(0, 1, 0, 0, 0, 0, 12'h222);
    cyc(1, 1, 0, 0, 0, 0, 12'h333);
    chk("rst_call_addr",  addressOut, 32'h100);
    chk("rst_call_cnt",   stackCount, 0);
    chk("rst_call_empty", stackEmpty, 1);
    chk("rst_call_tos",   topOfStack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
